uart_rx_oversampled: RTL and testbench

- Parametrised UART receiver. Generalises the current 8N1 receiver: configurable data width, oversampling ratio, parity mode and stop-bit count.
- Adds a 2-FF input synchroniser, 3-sample majority voting, false-start rejection, parity and framing error flags, and break recovery.
- Sits between the board RX pin and the command decoder.
- Uses the shared baud generator's sample_tick (OVERSAMPLE ticks per bit).

---
 rtl/uart_rx_oversampled_if.sv | 23 ++
 rtl/uart_rx_oversampled.sv | 148 ++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_oversampled_if.sv
// Serial-side and payload-side signals of the oversampled UART receiver.
// master = the receiver, slave = the line driver / payload consumer.
interface uart_rx_oversampled_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic                 sample_tick;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx, sample_tick,
        output data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        output rx, sample_tick,
        input  data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Parametrised oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote,
// false-start rejection, parity/framing flags and break recovery.
module uart_rx_oversampled #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                  clk_50MHz,
    input  logic                  reset_n,
    uart_rx_oversampled_if.master bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned M  = OVERSAMPLE / 2;
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_V0  = TW'(M - 1);
    localparam logic [TW-1:0] T_V1  = TW'(M);
    localparam logic [TW-1:0] T_V2  = TW'(M + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t               state;
    logic                 rx_meta, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 samp0, samp1;
    logic                 pe_pend, fe_pend;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 data_valid_q, parity_err_q, frame_err_q, busy_q;

    logic vote, at_vote, at_end, stop_fail, par_bad;

    always_comb begin
        vote      = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
        at_vote   = bus.sample_tick && (tick_cnt == T_V2);
        at_end    = bus.sample_tick && (tick_cnt == T_END);
        stop_fail = fe_pend | ~vote;
        par_bad   = 1'b0;
        if (PARITY_MODE == 2)
            par_bad = (^shift_reg) != vote;
        else if (PARITY_MODE == 1)
            par_bad = (^shift_reg) == vote;
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            samp0        <= 1'b1;
            samp1        <= 1'b1;
            pe_pend      <= 1'b0;
            fe_pend      <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta      <= bus.rx;
            rx_s         <= rx_meta;
            data_valid_q <= 1'b0;

            if (state != IDLE && state != WAIT_HIGH && bus.sample_tick) begin
                tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + TW'(1);
                if (tick_cnt == T_V0) samp0 <= rx_s;
                if (tick_cnt == T_V1) samp1 <= rx_s;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        pe_pend  <= 1'b0;
                        fe_pend  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (at_vote) begin
                        shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + BW'(1);
                    end
                    if (at_end && bit_cnt == BW'(DATA_BITS)) begin
                        bit_cnt <= '0;
                        state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (at_vote) pe_pend <= par_bad;
                    if (at_end) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    // Last stop bit completes at mid-bit so the next start edge is never missed.
                    if (at_vote) begin
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            data_out_q   <= shift_reg;
                            parity_err_q <= pe_pend;
                            frame_err_q  <= stop_fail;
                            data_valid_q <= 1'b1;
                            state        <= stop_fail ? WAIT_HIGH : IDLE;
                            busy_q       <= stop_fail;
                        end else begin
                            fe_pend <= stop_fail;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: 8N1, 8E1 and 8N2 instances share clock,
// reset and a 1-in-27 sample_tick; each has its own rx line and expected-frame queue.
module tb_uart_rx_oversampled;
    logic        clk_50MHz = 1'b0;
    logic        reset_n   = 1'b0;
    logic        sample_tick;
    int unsigned tick_div  = 0;
    logic        rx_drv [3];

    always #10 clk_50MHz = ~clk_50MHz;
    always @(posedge clk_50MHz) tick_div <= (tick_div == 26) ? 0 : tick_div + 1;
    assign sample_tick = (tick_div == 26);

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) bus2 ();

    assign bus0.rx = rx_drv[0];
    assign bus1.rx = rx_drv[1];
    assign bus2.rx = rx_drv[2];
    assign bus0.sample_tick = sample_tick;
    assign bus1.sample_tick = sample_tick;
    assign bus2.sample_tick = sample_tick;

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk_50MHz(clk_50MHz), .reset_n(reset_n), .bus(bus0));
    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) dut1 (
        .clk_50MHz(clk_50MHz), .reset_n(reset_n), .bus(bus1));
    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
        .clk_50MHz(clk_50MHz), .reset_n(reset_n), .bus(bus2));

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t        sb0[$], sb1[$], sb2[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int unsigned u, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        case (u)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    function automatic int unsigned pending(input int unsigned u);
        return (u == 0) ? sb0.size() : (u == 1) ? sb1.size() : sb2.size();
    endfunction

    task automatic score(input int unsigned u, input logic [7:0] d, input logic pe, input logic fe);
        exp_t        e;
        int unsigned n;
        n = pending(u);
        check_eq($sformatf("u%0d_valid_expected", u), 32'(n != 0), 32'd1);
        if (n == 0) return;
        case (u)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
        check_eq($sformatf("u%0d_data_out", u), 32'(d), 32'(e.data));
        check_eq($sformatf("u%0d_parity_err", u), 32'(pe), 32'(e.perr));
        check_eq($sformatf("u%0d_frame_err", u), 32'(fe), 32'(e.ferr));
    endtask

    always @(negedge clk_50MHz) if (bus0.data_valid === 1'b1) score(0, bus0.data_out, bus0.parity_err, bus0.frame_err);
    always @(negedge clk_50MHz) if (bus1.data_valid === 1'b1) score(1, bus1.data_out, bus1.parity_err, bus1.frame_err);
    always @(negedge clk_50MHz) if (bus2.data_valid === 1'b1) score(2, bus2.data_out, bus2.parity_err, bus2.frame_err);

    // Returns #1 after the clock edge on which the DUTs consume the n-th sample_tick.
    task automatic wait_ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            do @(negedge clk_50MHz); while (sample_tick !== 1'b1);
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    task automatic drive_bit(input int unsigned u, input logic v, input logic glitch);
        rx_drv[u] = v;
        if (glitch) begin
            wait_ticks(8);
            rx_drv[u] = ~v;
            wait_ticks(1);
            rx_drv[u] = v;
            wait_ticks(7);
        end else begin
            wait_ticks(16);
        end
    endtask

    // par < 0 means no parity bit; rx is left at the last stop-bit level.
    task automatic send_frame(input int unsigned u, input logic [7:0] d, input int par,
                              input int unsigned nstop, input logic last_stop, input int glitch_bit);
        drive_bit(u, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(u, d[i], i == glitch_bit);
        if (par >= 0) drive_bit(u, par[0], 1'b0);
        for (int unsigned s = 0; s < nstop; s++)
            drive_bit(u, (s == nstop - 1) ? last_stop : 1'b1, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_data_out"},   32'(bus0.data_out),   32'd0);
        check_eq({tag, "_data_valid"}, 32'(bus0.data_valid), 32'd0);
        check_eq({tag, "_parity_err"}, 32'(bus0.parity_err), 32'd0);
        check_eq({tag, "_frame_err"},  32'(bus0.frame_err),  32'd0);
        check_eq({tag, "_busy"},       32'(bus0.busy),       32'd0);
    endtask

    task automatic check_drained(input string tag);
        for (int unsigned u = 0; u < 3; u++)
            check_eq($sformatf("%s_u%0d_pending", tag, u), pending(u), 32'd0);
    endtask

    logic [7:0] c3;

    initial begin
        for (int i = 0; i < 3; i++) rx_drv[i] = 1'b1;
        repeat (5) @(negedge clk_50MHz);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        wait_ticks(4);

        // 8N1 basic frame
        push_exp(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, -1, 1, 1'b1, -1);
        wait_ticks(4);
        check_eq("t1_busy_low", 32'(bus0.busy), 32'd0);
        check_drained("t1");

        // even parity: good and bad parity bit, payload delivered both times
        push_exp(1, 8'h37, 1'b0 ^ ((^8'h37) != 1'b1), 1'b0);
        send_frame(1, 8'h37, 1, 1, 1'b1, -1);
        wait_ticks(2);
        push_exp(1, 8'h37, (^8'h37) != 1'b0, 1'b0);
        send_frame(1, 8'h37, 0, 1, 1'b1, -1);
        wait_ticks(4);
        check_drained("t2");

        // false start then a good frame
        rx_drv[0] = 1'b0;
        wait_ticks(5);
        rx_drv[0] = 1'b1;
        wait_ticks(16);
        check_eq("t3_busy_after_false_start", 32'(bus0.busy), 32'd0);
        push_exp(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, -1, 1, 1'b1, -1);
        wait_ticks(4);
        check_drained("t3");

        // single-tick glitch on data bit 7
        push_exp(0, 8'hFF, 1'b0, 1'b0);
        send_frame(0, 8'hFF, -1, 1, 1'b1, 7);
        wait_ticks(4);
        check_drained("t4");

        // framing error followed by a 40-bit break, then recovery
        push_exp(0, 8'h00, 1'b0, 1'b1);
        send_frame(0, 8'h00, -1, 1, 1'b0, -1);
        wait_ticks(40 * 16);
        check_eq("t5_busy_in_break", 32'(bus0.busy), 32'd1);
        check_eq("t5_frame_err_held", 32'(bus0.frame_err), 32'd1);
        rx_drv[0] = 1'b1;
        wait_ticks(16);
        check_eq("t5_busy_after_break", 32'(bus0.busy), 32'd0);
        push_exp(0, 8'h5A, 1'b0, 1'b0);
        send_frame(0, 8'h5A, -1, 1, 1'b1, -1);
        wait_ticks(4);
        check_drained("t5");

        // reset in the middle of data bit 4
        c3 = 8'hC3;
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, c3[i], 1'b0);
        rx_drv[0] = c3[4];
        wait_ticks(8);
        check_eq("t6_busy_mid_frame", 32'(bus0.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        repeat (3) @(negedge clk_50MHz);
        rx_drv[0] = 1'b1;
        repeat (3) @(negedge clk_50MHz);
        reset_n = 1'b1;
        wait_ticks(20);
        push_exp(0, 8'hC3, 1'b0, 1'b0);
        send_frame(0, 8'hC3, -1, 1, 1'b1, -1);
        wait_ticks(4);

        // two stop bits: clean, second stop low, then recovery
        push_exp(2, 8'h96, 1'b0, 1'b0);
        send_frame(2, 8'h96, -1, 2, 1'b1, -1);
        push_exp(2, 8'h69, 1'b0, 1'b1);
        send_frame(2, 8'h69, -1, 2, 1'b0, -1);
        rx_drv[2] = 1'b1;
        wait_ticks(16);
        check_eq("t6_stop2_busy_low", 32'(bus2.busy), 32'd0);
        push_exp(2, 8'h81, 1'b0, 1'b0);
        send_frame(2, 8'h81, -1, 2, 1'b1, -1);
        wait_ticks(4);
        check_drained("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
